// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host-to-device transmitter: FSM state codes,
// filter and frame sizes, default timing, and the frame-building helper.
package ps2_pkg;

    localparam int FILTER_LEN         = 8;
    localparam int FRAME_BITS         = 9;
    localparam int INHIBIT_CYCLES_DEF = 6000;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_ACK   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_ACK   = 3'd5,
        S_DONE  = 3'd6
    } ps2_state_e;

    // Data byte with its odd-parity bit on top, shifted out LSB first.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side command handshake of the PS/2 transmitter: the host issues
// wr_ps2/din, the transmitter reports idle, completion and error.
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
    modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock pin with an 8-sample window and produces a
// one-cycle tick on every filtered falling edge.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic clk_filt,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filt_r;
    logic [FILTER_LEN-1:0] filt_next_s;
    logic                  level_r;
    logic                  level_next_s;
    logic                  fall_r;

    // Next sample window and hysteretic filtered level
    always_comb begin
        filt_next_s = {filt_r[FILTER_LEN-2:0], ps2c_in};
        if (&filt_next_s) begin
            level_next_s = 1'b1;
        end else if (~|filt_next_s) begin
            level_next_s = 1'b0;
        end else begin
            level_next_s = level_r;
        end
    end

    // Filter window, filtered level and falling-edge tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_r  <= {FILTER_LEN{1'b1}};
            level_r <= 1'b1;
            fall_r  <= 1'b0;
        end else begin
            filt_r  <= filt_next_s;
            level_r <= level_next_s;
            fall_r  <= level_r & ~level_next_s;
        end
    end

    assign clk_filt  = level_r;
    assign fall_edge = fall_r;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter. Define PS2_TX_TIMEOUT_EN to add a
// watchdog that aborts a transfer when the device stops clocking.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    ps2_tx_if.slave  host,
    input  logic     ps2c_in,
    input  logic     ps2d_in,
    output logic     ps2c_oe,
    output logic     ps2d_oe
);

    localparam int RTS_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int IDX_W = $clog2(FRAME_BITS + 1);

    logic [2:0]            state_r,   state_n_s;
    logic [FRAME_BITS-1:0] shift_r,   shift_n_s;
    logic [IDX_W-1:0]      idx_r,     idx_n_s;
    logic [RTS_W-1:0]      rts_cnt_r, rts_cnt_n_s;
    logic                  err_r,     err_n_s;
    logic                  done_s;
    logic                  clk_filt_s, fall_s;
    logic                  ps2c_oe_r, ps2d_oe_r;
    logic                  tx_idle_r, tx_done_tick_r, tx_err_r;
    logic                  wd_expire_s;

    ps2_clk_filter u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c_in),
        .clk_filt  (clk_filt_s),
        .fall_edge (fall_s)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;
    logic            wd_active_s;

    assign wd_active_s = (state_r == ST_START) || (state_r == ST_DATA) ||
                         (state_r == ST_STOP)  || (state_r == ST_ACK);
    assign wd_expire_s = wd_active_s && !fall_s &&
                         (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Cycles since the last device clock edge while the device owns the clock
    always_ff @(posedge clk) begin
        if (reset || !wd_active_s || fall_s) begin
            wd_cnt_r <= '0;
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next-state logic; a watchdog expiry overrides the frame sequencing
    always_comb begin
        state_n_s   = state_r;
        shift_n_s   = shift_r;
        idx_n_s     = idx_r;
        rts_cnt_n_s = rts_cnt_r;
        err_n_s     = err_r;
        done_s      = 1'b0;
        if (wd_expire_s) begin
            state_n_s = ST_DONE;
            err_n_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // tx_idle_r is low on the done-tick cycle, so requests there are dropped
                    if (host.wr_ps2 && tx_idle_r) begin
                        state_n_s   = ST_RTS;
                        shift_n_s   = make_frame(host.din);
                        idx_n_s     = '0;
                        rts_cnt_n_s = '0;
                        err_n_s     = 1'b0;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RTS: begin
                    if (rts_cnt_r == RTS_W'(INHIBIT_CYCLES - 1)) begin
                        state_n_s = ST_START;
                    end else begin
                        rts_cnt_n_s = rts_cnt_r + RTS_W'(1);
                    end
                end
                ST_START: begin
                    if (fall_s) begin
                        state_n_s = ST_DATA;
                        idx_n_s   = '0;
                    end else begin
                        state_n_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (fall_s) begin
                        shift_n_s = {1'b0, shift_r[FRAME_BITS-1:1]};
                        if (idx_r == IDX_W'(FRAME_BITS - 1)) begin
                            state_n_s = ST_STOP;
                        end else begin
                            idx_n_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        state_n_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (fall_s) begin
                        state_n_s = ST_ACK;
                    end else begin
                        state_n_s = ST_STOP;
                    end
                end
                ST_ACK: begin
                    if (fall_s) begin
                        err_n_s   = ps2d_in;
                        state_n_s = ST_DONE;
                    end else begin
                        state_n_s = ST_ACK;
                    end
                end
                ST_DONE: begin
                    if (clk_filt_s && ps2d_in) begin
                        done_s    = 1'b1;
                        state_n_s = ST_IDLE;
                    end else begin
                        state_n_s = ST_DONE;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs (outputs follow the next state)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            shift_r        <= '0;
            idx_r          <= '0;
            rts_cnt_r      <= '0;
            err_r          <= 1'b0;
            ps2c_oe_r      <= 1'b0;
            ps2d_oe_r      <= 1'b0;
            tx_idle_r      <= 1'b1;
            tx_done_tick_r <= 1'b0;
            tx_err_r       <= 1'b0;
        end else begin
            state_r        <= state_n_s;
            shift_r        <= shift_n_s;
            idx_r          <= idx_n_s;
            rts_cnt_r      <= rts_cnt_n_s;
            err_r          <= err_n_s;
            ps2c_oe_r      <= (state_n_s == ST_RTS);
            ps2d_oe_r      <= (state_n_s == ST_START) ||
                              ((state_n_s == ST_DATA) && !shift_n_s[0]);
            tx_idle_r      <= (state_n_s == ST_IDLE) && !done_s;
            tx_done_tick_r <= done_s;
            tx_err_r       <= done_s ? err_n_s : tx_err_r;
        end
    end

    assign ps2c_oe           = ps2c_oe_r;
    assign ps2d_oe           = ps2d_oe_r;
    assign host.tx_idle      = tx_idle_r;
    assign host.tx_done_tick = tx_done_tick_r;
    assign host.tx_err       = tx_err_r;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out of the
// DUT, a frame/parity model predicts the bits, and a monitor checks every cycle.
module tb_ps2_tx;

    localparam int INH = 60;
    localparam int TMO = 3000;
    localparam int HP  = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2c_oe, ps2d_oe;
    logic ps2c_in, ps2d_in;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic exp_pending = 1'b0;
    logic exp_err = 1'b0;
    logic [10:0] frame_got;

    ps2_tx_if bus ();

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .host    (bus),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wire order as seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("oe_exclusive", {31'd0, ps2c_oe & ps2d_oe}, 32'd0);
                if (bus.tx_idle) check("idle_released", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
                if (bus.tx_done_tick) begin
                    done_cnt++;
                    check("done_expected", {31'd0, exp_pending}, 32'd1);
                    check("tx_err", {31'd0, bus.tx_err}, {31'd0, exp_err});
                    exp_pending = 1'b0;
                end
            end
        end
    endtask

    task automatic request(input logic [7:0] d);
        int n;
        @(negedge clk);
        bus.wr_ps2 = 1'b1;
        bus.din    = d;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        check("rts_latency", {31'd0, ps2c_oe}, 32'd1);
        n = 0;
        while (ps2c_oe && n < INH + 10) begin
            n++;
            @(negedge clk);
        end
        check("rts_len", n, INH);
        check("start_bit_oe", {31'd0, ps2d_oe}, 32'd1);
    endtask

    task automatic dev_pulse();
        dev_c_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input bit glitch,
                        input bit wr_on_done, input bit use_lit, input logic [10:0] lit);
        int n;
        int start_cnt;
        logic [10:0] exp_frame;
        exp_frame = model_frame(d);
        if (use_lit) check("model_literal", {21'd0, exp_frame}, {21'd0, lit});
        start_cnt   = done_cnt;
        exp_pending = 1'b1;
        exp_err     = !ack;
        request(d);
        frame_got = '0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            frame_got[i] = ps2d_in;
            if (glitch && i == 4) begin
                bus.wr_ps2 = 1'b1;
                bus.din    = 8'h00;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                dev_c_low = 1'b1; repeat (5) @(negedge clk);
                dev_c_low = 1'b0; repeat (3) @(negedge clk);
                dev_c_low = 1'b1; repeat (7) @(negedge clk);
                dev_c_low = 1'b0; repeat (HP) @(negedge clk);
            end
            dev_pulse();
        end
        if (ack) dev_d_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_pulse();
        dev_d_low = 1'b0;
        n = 0;
        while (!bus.tx_done_tick && done_cnt == start_cnt && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("done_seen", {31'd0, (done_cnt != start_cnt) || bus.tx_done_tick}, 32'd1);
        if (wr_on_done) begin
            check("tick_at_poll", {31'd0, bus.tx_done_tick}, 32'd1);
            bus.wr_ps2 = 1'b1;
            bus.din    = 8'h55;
            @(negedge clk);
            bus.wr_ps2 = 1'b0;
            check("wr_on_done_ignored", {31'd0, ps2c_oe}, 32'd0);
            check("idle_after_done", {31'd0, bus.tx_idle}, 32'd1);
        end
        repeat (5) @(negedge clk);
        check("no_restart", {31'd0, ps2c_oe}, 32'd0);
        check("frame", {21'd0, frame_got}, {21'd0, exp_frame});
    endtask

    initial begin
        int n;
        int start_cnt;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        fork
            monitor();
            begin
                repeat (60000) @(negedge clk);
                $display("FAIL global_timeout: got running expected finished");
                $fatal(1, "bench cycle budget exhausted");
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_ps2c_oe", {31'd0, ps2c_oe}, 32'd0);
        check("rst_ps2d_oe", {31'd0, ps2d_oe}, 32'd0);
        check("rst_tx_idle", {31'd0, bus.tx_idle}, 32'd1);
        check("rst_done", {31'd0, bus.tx_done_tick}, 32'd0);
        check("rst_err", {31'd0, bus.tx_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7DA);
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 11'h402);
        send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 11'h7FE);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000);

        // Device never clocks after the request-to-send
        start_cnt = done_cnt;
`ifdef PS2_TX_TIMEOUT_EN
        exp_pending = 1'b1;
        exp_err     = 1'b1;
        request(8'h3C);
        n = 0;
        while (ps2d_oe && n < TMO + 10) begin
            n++;
            @(negedge clk);
        end
        check("wd_len", n, TMO);
        check("wd_release", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        n = 0;
        while (done_cnt == start_cnt && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("wd_done", done_cnt - start_cnt, 1);
`else
        exp_pending = 1'b0;
        request(8'h3C);
        repeat (TMO + 200) @(negedge clk);
        check("no_wd_in_start", {30'd0, ps2c_oe, ps2d_oe}, 32'd1);
        check("no_wd_done", done_cnt - start_cnt, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (5) @(negedge clk);

        // Reset while presenting data bit 4
        start_cnt   = done_cnt;
        exp_pending = 1'b0;
        request(8'hA5);
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 5; i++) dev_pulse();
        check("abort_bit4_low", {31'd0, ps2d_oe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_c_rel", {31'd0, ps2c_oe}, 32'd0);
        check("abort_d_rel", {31'd0, ps2d_oe}, 32'd0);
        check("abort_idle", {31'd0, bus.tx_idle}, 32'd1);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_done", done_cnt - start_cnt, 0);

        send(8'hF4, 1'b1, 1'b0, 1'b0, 1'b1, 11'h5E8);
        send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 11'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, default 6000, clock-low request-to-send hold time in clk cycles (120 us at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1000000, maximum clk cycles allowed between device clock falling edges (20 ms at 50 MHz).
REQ-003 clk  in  1  system clock (CLOCK_50 domain); single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_ps2  in  1  one-cycle request to transmit din.
REQ-006 din  in  8  command byte to send to the device.
REQ-007 ps2c_in, ps2d_in  in  1 each  sampled PS/2 clock and data pin levels.
REQ-008 ps2c_oe, ps2d_oe  out  1 each  1 = drive the pin low; 0 = release (pulled high).
REQ-009 tx_idle  out  1  high only in IDLE; drives the receiver's rx_en.
REQ-010 tx_done_tick  out  1  one-cycle pulse at the end of every transfer, including aborted ones.
REQ-011 tx_err  out  1  valid with tx_done_tick; 1 = no ACK or timeout.

Function
REQ-012 ps2c_in shall pass through an 8-sample shift filter: the filtered clock goes 1 when all 8 samples are 1, goes 0 when all 8 are 0, and otherwise holds.
REQ-013 fall_edge shall be a one-cycle tick on each filtered 1->0 transition.
REQ-014 States: IDLE, RTS, START, DATA, STOP, ACK, DONE.
REQ-015 IDLE: both oe=0; wr_ps2=1 latches shift[8:0] = {~^din, din} (odd parity), clears the counters, and enters RTS; wr_ps2 outside IDLE is ignored.
REQ-016 RTS: ps2c_oe=1 for exactly INHIBIT_CYCLES cycles, then enter START.
REQ-017 START: ps2c_oe=0 and ps2d_oe=1 (start bit); the first fall_edge enters DATA with bit index 0.
REQ-018 DATA: ps2d_oe = ~shift[0]; each fall_edge shifts right and increments the index.
REQ-019 DATA: the fall_edge at index 8 enters STOP, so 9 bits (data LSB first, then parity) are presented.
REQ-020 STOP: ps2d_oe=0 (stop bit 1); the next fall_edge enters ACK.
REQ-021 ACK: ps2d_in is sampled on the next fall_edge; sampled 0 = acknowledged, 1 = error.
REQ-022 DONE: wait until the filtered clock = 1 and ps2d_in = 1, then pulse tx_done_tick for one cycle with the stored tx_err and return to IDLE.
REQ-023 Latency: wr_ps2 to ps2c_oe=1 is 1 cycle.
REQ-024 A fall_edge arriving in IDLE or RTS shall be ignored.
REQ-025 wr_ps2 on the same cycle as tx_done_tick shall be ignored, because the FSM is not yet in IDLE.

Reset
REQ-026 On reset: state=IDLE, ps2c_oe=0, ps2d_oe=0, tx_idle=1 on the following cycle.
REQ-027 On reset: tx_done_tick=0, tx_err=0, shift=0, counters=0, filter register=all ones.
REQ-028 Reset asserted mid-transfer shall abort the transfer, release both lines on the next edge, and produce no tx_done_tick.

Configuration
REQ-029 Macro PS2_TX_TIMEOUT_EN, when defined, enables the watchdog.
REQ-030 With PS2_TX_TIMEOUT_EN: in START through ACK, a counter resets on each fall_edge.
REQ-031 With PS2_TX_TIMEOUT_EN: if that counter reaches TIMEOUT_CYCLES, release both lines, enter DONE with tx_err=1, and still wait for idle lines.
REQ-032 Without PS2_TX_TIMEOUT_EN: no watchdog logic exists, and tx_err reflects the ACK only.

Structure
REQ-033 Package ps2_pkg shall hold the FSM state enum, the filter length (8), the frame bit count (9), and the default INHIBIT/TIMEOUT constants.
REQ-034 Sub-module ps2_clk_filter shall contain the filter and the fall_edge detector.

Verification
REQ-035 Device model clocks at 4000-cycle period; send din=0xED -> ps2c_oe high 6000 cycles, then bits sampled on rising edges are 0,1,0,1,1,0,1,1,1,1(parity),1(stop); model ACKs low -> tx_done_tick=1, tx_err=0.
REQ-036 din=0x01 -> parity bit 0; din=0xFF -> parity bit 1; both complete with tx_err=0.
REQ-037 Model omits the ACK (ps2d stays 1) -> tx_done_tick with tx_err=1.
REQ-038 With PS2_TX_TIMEOUT_EN: device never clocks after RTS -> at START entry + 1000000 cycles both oe=0 and tx_done_tick with tx_err=1; without the macro the FSM stays in START.
REQ-039 Reset asserted at DATA index 4 -> next cycle both oe=0 and tx_idle=1; no tx_done_tick; a following send of 0xF4 completes normally.
REQ-040 8-cycle glitch-free 0 pulses shorter than 8 samples on ps2c_in during DATA -> no shift occurs; wr_ps2 pulsed in DATA -> ignored.
